fft_twiddle_gen: RTL

Sequential twiddle-factor generator for the radix-2 DIT butterfly FFT datapath. On `start` it streams every twiddle W_N^k = cos(2πk/N) − j·sin(2πk/N), as IEEE-754 single-precision real/imaginary pairs, in stage-major, butterfly-minor order. It sits directly upstream of the floating-point multiplier, which takes each word as its twiddle operand. A valid/ready handshake allows the consumer to stall.

---
 rtl/fft_pkg.sv | 51 +++++
 rtl/fft_tw_rom.sv | 40 ++++
 rtl/fft_twiddle_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT datapath: quarter-wave cosine table
// for N = 1024 (entries rounded to nearest single precision), float constants, FSM states.
package fft_pkg;

    localparam int FFT_LOG2N_MAX = 10;
    localparam int QW_N_MAX      = 1 << FFT_LOG2N_MAX;
    localparam int QW_ENTRIES    = QW_N_MAX / 4 + 1;

    localparam logic [31:0] FP_ONE  = 32'h3F800000;
    localparam logic [31:0] FP_ZERO = 32'h00000000;

    localparam real TWO_PI = 6.283185307179586476925;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tw_state_e;

    // Double to single precision, round to nearest even; only normal magnitudes occur here.
    function automatic logic [31:0] real_to_fp32(input real v);
        logic [63:0] d;
        logic [7:0]  e8;
        logic [22:0] m;
        logic        rnd;
        d = $realtobits(v);
        if (d[62:0] == 63'd0) begin
            return FP_ZERO;
        end
        e8  = 8'(int'(d[62:52]) - 1023 + 127);
        m   = d[51:29];
        rnd = d[28] && ((|d[27:0]) || m[0]);
        return {d[63], {e8, m} + 31'(rnd)};
    endfunction

    // Entry i of the 1024-point quarter-wave table, i = 0..QW_ENTRIES-1.
    function automatic logic [31:0] qw_cos_1024(input int i);
        if (i <= 0) begin
            return FP_ONE;
        end
        if (i >= QW_ENTRIES - 1) begin
            return FP_ZERO;
        end
        return real_to_fp32($cos(TWO_PI * i / QW_N_MAX));
    endfunction

    // Sign flip that never produces -0.
    function automatic logic [31:0] fp_neg(input logic [31:0] x);
        return (x[30:0] == 31'd0) ? FP_ZERO : {~x[31], x[30:0]};
    endfunction

endpackage

// File: rtl/fft_tw_rom.sv
// Combinational quarter-wave lookup: folds k in [0, N/2) onto the strided
// 1024-point table and returns cosine and sine magnitudes.
module fft_tw_rom
    import fft_pkg::*;
#(
    parameter int LOG2N = 3
) (
    input  logic [LOG2N-2:0] k,
    output logic [31:0]      cos_mag,
    output logic [31:0]      sin_mag
);

    localparam int N      = 1 << LOG2N;
    localparam int QTR    = N / 4;
    localparam int KW     = LOG2N - 1;
    localparam int STRIDE = QW_N_MAX / N;

    logic [31:0]   qw [QTR+1];
    logic [KW-1:0] cos_idx;
    logic [KW-1:0] sin_idx;

    for (genvar i = 0; i <= QTR; i++) begin : g_qw
        assign qw[i] = qw_cos_1024(i * STRIDE);
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cos_idx = k;
        sin_idx = KW'(QTR) - k;
        // Second quadrant: cosine mirrors about N/4, sine runs back up the table.
        if (int'(k) > QTR) begin
            cos_idx = KW'(N / 2 - int'(k));
            sin_idx = k - KW'(QTR);
        end
    end

    assign cos_mag = qw[cos_idx];
    assign sin_mag = qw[sin_idx];

endmodule

// File: rtl/fft_twiddle_gen.sv
// Streams radix-2 DIT twiddles stage-major with a valid/ready handshake.
// Define FFT_TW_IFFT_EN to add the 'inverse' port (conjugate twiddles for the IFFT).
module fft_twiddle_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
`ifdef FFT_TW_IFFT_EN
    input  logic                       inverse,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       tw_valid,
    input  logic                       tw_ready,
    output logic [31:0]                tw_re,
    output logic [31:0]                tw_im,
    output logic [$clog2(LOG2N)-1:0]   tw_stage,
    output logic [LOG2N-2:0]           tw_idx,
    output logic                       tw_last
);

    localparam int N  = 1 << LOG2N;
    localparam int SW = $clog2(LOG2N);
    localparam int KW = LOG2N - 1;

    localparam logic [SW-1:0] LAST_S = SW'(LOG2N - 1);
    localparam logic [KW-1:0] LAST_J = '1;
    localparam logic [KW-1:0] QTR_K  = KW'(N / 4);

    tw_state_e     state;
    logic [SW-1:0] pos_s;
    logic [KW-1:0] pos_j;
    logic [KW-1:0] mask;
    logic [KW-1:0] k;
    logic          pos_last;
    logic [31:0]   cos_mag;
    logic [31:0]   sin_mag;
    logic [31:0]   nxt_re;
    logic [31:0]   nxt_im;
    logic          inv_sel;
    logic          handshake;
    logic          load;

    assign handshake = tw_valid && tw_ready;
    assign load      = (state == ST_IDLE) ? start : (handshake && !tw_last);

    // Position of the word to be registered next: (0,0) on start, else the successor of the output.
    always_comb begin
        pos_s = '0;
        pos_j = '0;
        if (state == ST_RUN) begin
            if (tw_idx == LAST_J) begin
                pos_s = tw_stage + SW'(1);
            end else begin
                pos_s = tw_stage;
                pos_j = tw_idx + KW'(1);
            end
        end
        mask     = (KW'(1) << pos_s) - KW'(1);
        k        = (pos_j & mask) << (LAST_S - pos_s);
        pos_last = (pos_s == LAST_S) && (pos_j == LAST_J);
    end

    fft_tw_rom #(
        .LOG2N   (LOG2N)
    ) u_rom (
        .k       (k),
        .cos_mag (cos_mag),
        .sin_mag (sin_mag)
    );

`ifdef FFT_TW_IFFT_EN
    logic inv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            inv_q <= inverse;
        end
    end

    // The first word is looked up in the start cycle, before inv_q has loaded.
    assign inv_sel = (state == ST_IDLE) ? inverse : inv_q;
`else
    assign inv_sel = 1'b0;
`endif

    assign nxt_re = (k > QTR_K) ? fp_neg(cos_mag) : cos_mag;
    assign nxt_im = inv_sel ? sin_mag : fp_neg(sin_mag);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            tw_valid <= 1'b0;
            tw_last  <= 1'b0;
            tw_re    <= FP_ZERO;
            tw_im    <= FP_ZERO;
            tw_stage <= '0;
            tw_idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        busy     <= 1'b1;
                        tw_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (handshake && tw_last) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        tw_valid <= 1'b0;
                        tw_last  <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (load) begin
                tw_re    <= nxt_re;
                tw_im    <= nxt_im;
                tw_stage <= pos_s;
                tw_idx   <= pos_j;
                tw_last  <= pos_last;
            end
        end
    end

endmodule
